// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2:1 round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned MUX_ARB_WIDTH = 8;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    // Maps a B-grant onto the side encoding stored in the round-robin pointer.
    function automatic logic granted_side(input logic grant_b);
        return grant_b ? SIDE_B : SIDE_A;
    endfunction

endpackage

// File: rtl/mux_arb_rr_grant.sv
// Combinational grant decision for the 2:1 mux arbiter.
// Build option: MUX_ARB_FIXED_PRIO_EN selects fixed priority (A wins ties).
module mux_arb_rr_grant
    import mux_arb_pkg::*;
(
    input  logic A_valid,
    input  logic B_valid,
    input  logic last,
    input  logic load,
    output logic grant_A,
    output logic grant_B
);

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        grant_A = 1'b0;
        grant_B = 1'b0;
        if (load) begin
            if (A_valid && B_valid) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                grant_A = 1'b1;
`else
                // Tie: serve the side that did not win the previous transfer.
                if (last == SIDE_B) begin
                    grant_A = 1'b1;
                end else begin
                    grant_B = 1'b1;
                end
`endif
            end else begin
                grant_A = A_valid;
                grant_B = B_valid;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_2to1.sv
// Two-producer round-robin arbiter driving a 2:1 mux select and a one-entry output register.
// Build option: MUX_ARB_FIXED_PRIO_EN (handled inside mux_arb_rr_grant).
module mux_arbiter_2to1
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_ARB_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A_data,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B_data,
    output logic             B_ready,
    output logic             Select,
    output logic             Y_valid,
    output logic [WIDTH-1:0] Y_data,
    input  logic             Y_ready
);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;

    logic load;
    logic grant_A;
    logic grant_B;
    logic transfer;

    // Output register can take a word when empty, or when the consumer drains it this cycle.
    assign load = !reset && ((state_q == ARB_EMPTY) || Y_ready);

    mux_arb_rr_grant u_grant (
        .A_valid (A_valid),
        .B_valid (B_valid),
        .last    (last_q),
        .load    (load),
        .grant_A (grant_A),
        .grant_B (grant_B)
    );

    assign transfer = grant_A || grant_B;

    assign A_ready = load && grant_A;
    assign B_ready = load && grant_B;
    assign Select  = grant_B;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        y_data_d = y_data_q;
        if (transfer) begin
            y_data_d = Select ? B_data : A_data;
            state_d  = ARB_FULL;
            last_d   = granted_side(grant_B);
        end else if ((state_q == ARB_FULL) && Y_ready) begin
            state_d  = ARB_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_EMPTY;
            last_q   <= SIDE_B;
            y_data_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            y_data_q <= y_data_d;
        end
    end

    assign Y_valid = (state_q == ARB_FULL);
    assign Y_data  = y_data_q;

`ifndef SYNTHESIS
    a_one_hot_ready : assert property (@(posedge clk) disable iff (reset)
        !(A_ready && B_ready));
    a_ready_needs_valid : assert property (@(posedge clk) disable iff (reset)
        (!A_ready || A_valid) && (!B_ready || B_valid));
    a_hold_when_stalled : assert property (@(posedge clk) disable iff (reset)
        (Y_valid && !Y_ready) |=> (Y_valid && $stable(Y_data)));
`endif

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Directed self-checking bench for mux_arbiter_2to1.
module tb_mux_arbiter_2to1;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         A_valid;
    logic [W-1:0] A_data;
    logic         A_ready;
    logic         B_valid;
    logic [W-1:0] B_data;
    logic         B_ready;
    logic         Select;
    logic         Y_valid;
    logic [W-1:0] Y_data;
    logic         Y_ready;

    int unsigned n_checks;
    int unsigned n_fail;

    mux_arbiter_2to1 #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .A_valid (A_valid),
        .A_data  (A_data),
        .A_ready (A_ready),
        .B_valid (B_valid),
        .B_data  (B_data),
        .B_ready (B_ready),
        .Select  (Select),
        .Y_valid (Y_valid),
        .Y_data  (Y_data),
        .Y_ready (Y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        A_valid = 1'b0;
        B_valid = 1'b0;
        A_data  = '0;
        B_data  = '0;
        Y_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b1;
        A_valid = 1'b1;
        B_valid = 1'b1;
        Y_ready = 1'b1;
        #1;
        n_checks++;
        if ({A_ready, B_ready, Select} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_readies: got %b, want 000", {A_ready, B_ready, Select});
        end
        @(posedge clk); #1;
        @(negedge clk);
        A_valid = 1'b0;
        B_valid = 1'b0;
        reset   = 1'b0;
        #1;
        n_checks++;
        if ({Y_valid, Y_data, Select, A_ready, B_ready} !== {1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_idle: got valid=%b data=%h sel=%b ar=%b br=%b, want 0 00 0 0 0",
                     Y_valid, Y_data, Select, A_ready, B_ready);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        A_valid = 1'b1;
        A_data  = 8'h3C;
        Y_ready = 1'b1;
        #1;
        n_checks++;
        if ({A_ready, B_ready, Select} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_grant: got ar/br/sel=%b, want 100", {A_ready, B_ready, Select});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({Y_valid, Y_data} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL single_data: got valid=%b data=%h, want 1 3c", Y_valid, Y_data);
        end
        @(negedge clk);
        A_valid = 1'b0;
    endtask

    task automatic test_tie_alternation();
        logic [3:0] exp_sel;
        logic [W-1:0] exp_data;
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp_sel = 4'b0000;
`else
        exp_sel = 4'b1010;
`endif
        do_reset();
        Y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A_valid = 1'b1;
            B_valid = 1'b1;
            A_data  = 8'hA0 + 8'(i);
            B_data  = 8'hB0 + 8'(i);
            #1;
            n_checks++;
            if ({Select, A_ready, B_ready} !== {exp_sel[i], !exp_sel[i], exp_sel[i]}) begin
                n_fail++;
                $display("FAIL tie_grant[%0d]: got sel/ar/br=%b, want %b", i,
                         {Select, A_ready, B_ready}, {exp_sel[i], !exp_sel[i], exp_sel[i]});
            end
            exp_data = exp_sel[i] ? (8'hB0 + 8'(i)) : (8'hA0 + 8'(i));
            @(posedge clk); #1;
            n_checks++;
            if ({Y_valid, Y_data} !== {1'b1, exp_data}) begin
                n_fail++;
                $display("FAIL tie_data[%0d]: got valid=%b data=%h, want 1 %h", i,
                         Y_valid, Y_data, exp_data);
            end
            @(negedge clk);
        end
        A_valid = 1'b0;
        B_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        A_valid = 1'b1;
        A_data  = 8'h11;
        Y_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        A_valid = 1'b0;
        B_valid = 1'b1;
        B_data  = 8'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({B_ready, A_ready, Select} !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got br/ar/sel=%b, want 000", i,
                         {B_ready, A_ready, Select});
            end
            @(posedge clk); #1;
            n_checks++;
            if ({Y_valid, Y_data} !== {1'b1, 8'h11}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h, want 1 11", i, Y_valid, Y_data);
            end
            @(negedge clk);
        end
        Y_ready = 1'b1;
        #1;
        n_checks++;
        if ({B_ready, Select} !== 2'b11) begin
            n_fail++;
            $display("FAIL bp_release: got br/sel=%b, want 11", {B_ready, Select});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({Y_valid, Y_data} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL bp_refill: got valid=%b data=%h, want 1 22", Y_valid, Y_data);
        end
        @(negedge clk);
        B_valid = 1'b0;
    endtask

    task automatic test_drain();
        // Continues from a FULL register holding 8'h22.
        Y_ready = 1'b1;
        #1;
        n_checks++;
        if ({A_ready, B_ready, Select} !== 3'b000) begin
            n_fail++;
            $display("FAIL drain_nogrant: got ar/br/sel=%b, want 000", {A_ready, B_ready, Select});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({Y_valid, Y_data} !== {1'b0, 8'h22}) begin
            n_fail++;
            $display("FAIL drain_empty: got valid=%b data=%h, want 0 22", Y_valid, Y_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        A_valid = 1'b1;
        A_data  = 8'hAA;
        Y_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({Y_valid, Y_data} !== {1'b1, 8'hAA}) begin
            n_fail++;
            $display("FAIL mid_load: got valid=%b data=%h, want 1 aa", Y_valid, Y_data);
        end
        @(negedge clk);
        reset   = 1'b1;
        Y_ready = 1'b1;
        B_valid = 1'b1;
        B_data  = 8'h55;
        #1;
        n_checks++;
        if ({A_ready, B_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_rst_ready: got ar/br=%b, want 00", {A_ready, B_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({Y_valid, Y_data} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_rst_clear: got valid=%b data=%h, want 0 00", Y_valid, Y_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({Select, A_ready, B_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL mid_first_tie: got sel/ar/br=%b, want 010", {Select, A_ready, B_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({Y_valid, Y_data} !== {1'b1, 8'hAA}) begin
            n_fail++;
            $display("FAIL mid_first_data: got valid=%b data=%h, want 1 aa", Y_valid, Y_data);
        end
        @(negedge clk);
        A_valid = 1'b0;
        B_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        A_valid  = 1'b0;
        B_valid  = 1'b0;
        A_data   = '0;
        B_data   = '0;
        Y_ready  = 1'b0;
        test_reset();
        test_single_source();
        test_tie_alternation();
        test_backpressure();
        test_drain();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
